// File: rtl/fsmc_initiator_if.sv
// -----------------------------------------------------------------------------
// fsmc_initiator_if
//
// Purpose: bundles the Wishbone classic slave port and the FSMC/SRAM-style
// control/address pins of the FSMC initiator. The bidirectional data bus
// (fsmc_dat) is not part of this bundle. It is a plain inout on the initiator,
// so the tri-state driver resolves on an ordinary wire shared with the peer.
//
// Handshake: a Wishbone request is presented by holding wb_cyc_i and wb_stb_i
// high together with wb_adr_i/wb_dat_i/wb_sel_i/wb_we_i. The initiator
// latches the request on the first clock edge it sees it while idle. It then
// answers with a single-cycle wb_ack_o, and wb_dat_o is valid in that cycle.
// The master must not start a new request in the ack cycle.
//
// Signals:
//   wb_adr_i  [31:0]  address, only [15:0] reaches the FSMC bus
//   wb_dat_i  [31:0]  write data
//   wb_dat_o  [31:0]  read data
//   wb_sel_i  [3:0]   byte selects, [1:0] low half-word, [3:2] high half-word
//   wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o
//   fsmc_adr  [15:0]  FSMC address
//   fsmc_ce_n, fsmc_we_n, fsmc_oe_n, fsmc_ub_n, fsmc_lb_n  active-low controls
//
// Modports: slave = the initiator's view, master = the bus master / bench view.
// -----------------------------------------------------------------------------
interface fsmc_initiator_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic        wb_ack_o;
  logic [15:0] fsmc_adr;
  logic        fsmc_ce_n;
  logic        fsmc_we_n;
  logic        fsmc_oe_n;
  logic        fsmc_ub_n;
  logic        fsmc_lb_n;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    output wb_dat_o, wb_ack_o,
    output fsmc_adr, fsmc_ce_n, fsmc_we_n, fsmc_oe_n, fsmc_ub_n, fsmc_lb_n
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    input  wb_dat_o, wb_ack_o,
    input  fsmc_adr, fsmc_ce_n, fsmc_we_n, fsmc_oe_n, fsmc_ub_n, fsmc_lb_n
  );
endinterface

// File: rtl/fsmc_initiator.sv
// -----------------------------------------------------------------------------
// fsmc_initiator
//
// Purpose: Wishbone classic slave that turns each 32-bit access into zero, one
// or two 16-bit asynchronous SRAM-style cycles on an external FSMC bus. The
// low half-word goes first and the high half-word second. Halves with no byte
// select are skipped. Each half runs SETUP -> STROBE -> HOLD -> TURN, and all
// phases are timed by one 8-bit down-counter.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   bus          fsmc_initiator_if.slave (Wishbone slave + FSMC control pins)
//   fsmc_dat     16-bit FSMC data, driven only while writing (SETUP..HOLD)
//   fsmc_nwait   active-low wait input, only with FSMC_INITIATOR_NWAIT_EN
//   o_dbg_state  current FSM state encoding, for observation
//
// Optional feature (macro FSMC_INITIATOR_NWAIT_EN): adds fsmc_nwait, which is
// synchronised through two flops. STROBE is extended while the synchronised
// wait is low. Without the macro, STROBE is exactly DATAST cycles.
//
// Parameters: ADDSET, DATAST, HOLD (0 treated as 1), TURN (values below 2
// treated as 2 so the responder always sees ce_n high long enough to go idle).
// -----------------------------------------------------------------------------
module fsmc_initiator #(
  parameter int ADDSET = 2,
  parameter int DATAST = 8,
  parameter int HOLD   = 1,
  parameter int TURN   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  fsmc_initiator_if.slave        bus,
  inout  wire  [15:0]            fsmc_dat,
`ifdef FSMC_INITIATOR_NWAIT_EN
  input  logic                   fsmc_nwait,
`endif
  output logic [2:0]             o_dbg_state
);

  localparam int ADDSET_E = (ADDSET < 1) ? 1 : ADDSET;
  localparam int DATAST_E = (DATAST < 1) ? 1 : DATAST;
  localparam int HOLD_E   = (HOLD   < 1) ? 1 : HOLD;
  localparam int TURN_E   = (TURN   < 2) ? 2 : TURN;

  // Counter reload values: a phase of N cycles loads N-1 and ends at zero.
  localparam logic [7:0] ADDSET_LD = 8'(ADDSET_E - 1);
  localparam logic [7:0] DATAST_LD = 8'(DATAST_E - 1);
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_E - 1);
  localparam logic [7:0] TURN_LD   = 8'(TURN_E - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_TURN   = 3'd4,
    S_ACK    = 3'd5
  } state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [15:0] r_adr;
  logic [31:0] r_wdat;
  logic [31:0] r_rdat;
  logic        r_we;
  logic        r_hi_half;   // half-word currently on the bus: 1 = high
  logic        r_hi_pend;   // high half still has to run

  state_t      w_state_nxt;
  logic [7:0]  w_cnt_nxt;
  logic        w_accept;
  logic        w_to_hi;
  logic        w_sample;
  logic        w_drive;
  logic        w_ack;
  logic        w_ce_n;
  logic        w_we_n;
  logic        w_oe_n;
  logic        w_ub_n;
  logic        w_lb_n;
  logic        w_done;
  logic        w_nwait_ok;
  logic [15:0] w_wdat_half;
  logic        w_unused;

  assign w_unused = ^bus.wb_adr_i[31:16];

`ifdef FSMC_INITIATOR_NWAIT_EN
  logic r_nwait_s1;
  logic r_nwait_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nwait_s1 <= 1'b1;
      r_nwait_s2 <= 1'b1;
    end else begin
      r_nwait_s1 <= fsmc_nwait;
      r_nwait_s2 <= r_nwait_s1;
    end
  end

  assign w_nwait_ok = r_nwait_s2;
`else
  assign w_nwait_ok = 1'b1;
`endif

  assign w_done      = (r_cnt == 8'd0);
  assign w_wdat_half = r_hi_half ? r_wdat[31:16] : r_wdat[15:0];

  // Next state, counter and pin decode. All FSMC pins are decoded from the
  // registered state, so an asynchronous reset releases them immediately.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_to_hi     = 1'b0;
    w_sample    = 1'b0;
    w_drive     = 1'b0;
    w_ack       = 1'b0;
    w_ce_n      = 1'b1;
    w_we_n      = 1'b1;
    w_oe_n      = 1'b1;
    w_ub_n      = 1'b1;
    w_lb_n      = 1'b1;

    case (r_state)
      S_IDLE: begin
        // wb_ack_o is only high in S_ACK, so it needs no term here.
        if (bus.wb_cyc_i && bus.wb_stb_i) begin
          w_accept = 1'b1;
          if (bus.wb_sel_i == 4'b0000) begin
            w_state_nxt = S_ACK;
          end else begin
            w_state_nxt = S_SETUP;
            w_cnt_nxt   = ADDSET_LD;
          end
        end
      end

      S_SETUP: begin
        w_ce_n  = 1'b0;
        w_ub_n  = !r_hi_half;
        w_lb_n  = r_hi_half;
        w_we_n  = !r_we;
        w_drive = r_we;
        if (w_done) begin
          w_state_nxt = S_STROBE;
          w_cnt_nxt   = DATAST_LD;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end

      S_STROBE: begin
        w_ce_n  = 1'b0;
        w_ub_n  = !r_hi_half;
        w_lb_n  = r_hi_half;
        w_we_n  = !r_we;
        w_oe_n  = r_we;
        w_drive = r_we;
        if (w_done) begin
          // The counter parks at zero while the peer holds off with nwait.
          if (w_nwait_ok) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = HOLD_LD;
            w_sample    = !r_we;
          end
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end

      S_HOLD: begin
        w_ce_n  = 1'b0;
        w_ub_n  = !r_hi_half;
        w_lb_n  = r_hi_half;
        w_drive = r_we;
        if (w_done) begin
          w_state_nxt = S_TURN;
          w_cnt_nxt   = TURN_LD;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end

      S_TURN: begin
        if (w_done) begin
          if (!r_hi_half && r_hi_pend) begin
            w_state_nxt = S_SETUP;
            w_cnt_nxt   = ADDSET_LD;
            w_to_hi     = 1'b1;
          end else begin
            w_state_nxt = S_ACK;
          end
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end

      S_ACK: begin
        w_ack       = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_adr     <= 16'd0;
      r_wdat    <= 32'd0;
      r_rdat    <= 32'd0;
      r_we      <= 1'b0;
      r_hi_half <= 1'b0;
      r_hi_pend <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_adr     <= bus.wb_adr_i[15:0];
        r_wdat    <= bus.wb_dat_i;
        r_we      <= bus.wb_we_i;
        r_rdat    <= 32'd0;
        // Start on the low half unless only the high half is selected.
        r_hi_half <= !(|bus.wb_sel_i[1:0]);
        r_hi_pend <= |bus.wb_sel_i[3:2];
      end
      if (w_to_hi) begin
        r_hi_half <= 1'b1;
      end
      if (w_sample) begin
        if (r_hi_half) begin
          r_rdat[31:16] <= fsmc_dat;
        end else begin
          r_rdat[15:0] <= fsmc_dat;
        end
      end
    end
  end

  assign fsmc_dat      = w_drive ? w_wdat_half : 16'hzzzz;
  assign bus.fsmc_adr  = r_adr;
  assign bus.fsmc_ce_n = w_ce_n;
  assign bus.fsmc_we_n = w_we_n;
  assign bus.fsmc_oe_n = w_oe_n;
  assign bus.fsmc_ub_n = w_ub_n;
  assign bus.fsmc_lb_n = w_lb_n;
  assign bus.wb_ack_o  = w_ack;
  assign bus.wb_dat_o  = r_rdat;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_fsmc_initiator.sv
// -----------------------------------------------------------------------------
// tb_fsmc_initiator
//
// Bench for fsmc_initiator. A small SRAM-like device model sits on the FSMC
// pins. A word-level reference memory predicts read data, ack latency and the
// expected FSMC activity of every access. The driver pushes a prediction into
// exp_q when it issues an access. A monitor observes the FSMC pins, pops the
// prediction when wb_ack_o appears, and compares the two.
// -----------------------------------------------------------------------------
module tb_fsmc_initiator;

  localparam int ADDSET   = 2;
  localparam int DATAST   = 8;
  localparam int HOLD     = 1;
  localparam int TURN     = 2;
  localparam int HALF_CYC = ADDSET + DATAST + HOLD + TURN;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  fsmc_initiator_if bus();
  wire [15:0] fsmc_dat;
  logic [2:0] unused_dbg_state;
`ifdef FSMC_INITIATOR_NWAIT_EN
  logic fsmc_nwait = 1'b1;
`endif

  fsmc_initiator #(
    .ADDSET(ADDSET), .DATAST(DATAST), .HOLD(HOLD), .TURN(TURN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .fsmc_dat   (fsmc_dat),
`ifdef FSMC_INITIATOR_NWAIT_EN
    .fsmc_nwait (fsmc_nwait),
`endif
    .o_dbg_state(unused_dbg_state)
  );

  // ---------------- device model (16-bit SRAM, 8 half-word pairs) ----------
  logic [15:0] init_lo [8];
  logic [15:0] init_hi [8];
  logic [15:0] dev_lo  [8];
  logic [15:0] dev_hi  [8];
  logic        dev_hit;
  logic [2:0]  dev_idx;
  logic        dev_drv;
  logic [15:0] dev_rd;

  always_comb begin
    dev_hit = (bus.fsmc_adr[15:5] == 11'h002);
    dev_idx = bus.fsmc_adr[4:2];
    dev_drv = !bus.fsmc_ce_n && !bus.fsmc_oe_n && dev_hit;
    dev_rd  = !bus.fsmc_lb_n ? dev_lo[dev_idx] : dev_hi[dev_idx];
  end

  assign fsmc_dat = dev_drv ? dev_rd : 16'hzzzz;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        dev_lo[i] <= init_lo[i];
        dev_hi[i] <= init_hi[i];
      end
    end else if (!bus.fsmc_ce_n && !bus.fsmc_we_n && dev_hit) begin
      if (!bus.fsmc_lb_n) dev_lo[dev_idx] <= fsmc_dat;
      if (!bus.fsmc_ub_n) dev_hi[dev_idx] <= fsmc_dat;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [8];

  task automatic ref_reload();
    for (int i = 0; i < 8; i++) ref_mem[i] = {init_hi[i], init_lo[i]};
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] rdat;
    logic        we;
    logic [1:0]  halves;
    logic [15:0] adr;
    logic [3:0]  order;
    logic [31:0] start;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- driver ----------------
  task automatic do_access(input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic we, input bit drop_cyc);
    exp_t        e;
    logic [2:0]  idx;
    bit          lo;
    bit          hi;
    bit          got;
    idx = adr[4:2];
    lo  = |sel[1:0];
    hi  = |sel[3:2];
    e.we     = we;
    e.adr    = adr[15:0];
    e.halves = 2'(int'(lo) + int'(hi));
    e.order  = 4'b0000;
    if (lo) e.order = {e.order[1:0], 2'b01};
    if (hi) e.order = {e.order[1:0], 2'b10};
    e.rdat = 32'd0;
    if (we) begin
      if (lo) ref_mem[idx][15:0]  = dat[15:0];
      if (hi) ref_mem[idx][31:16] = dat[31:16];
    end else begin
      if (lo) e.rdat[15:0]  = ref_mem[idx][15:0];
      if (hi) e.rdat[31:16] = ref_mem[idx][31:16];
    end
    e.start = 32'(cyc_cnt);
    exp_q.push_back(e);
    bus.wb_adr_i = adr;
    bus.wb_dat_i = dat;
    bus.wb_sel_i = sel;
    bus.wb_we_i  = we;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (drop_cyc && k == 3) begin
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
      end
      if (bus.wb_ack_o) got = 1'b1;
    end
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    if (!got) begin
      n_checks++;
      $display("FAIL ack_timeout: no ack within 200 cycles for adr 0x%08h", adr);
    end
    @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  logic        prev_ack   = 1'b0;
  logic        prev_ce_n  = 1'b1;
  int          m_halves   = 0;
  logic [3:0]  m_order    = 4'b0000;
  int          m_overlap  = 0;
  int          m_oe_cnt   = 0;
  int          m_we_cnt   = 0;
  int          m_gap      = 0;
  int          m_adr_err  = 0;
  logic [15:0] m_adr      = 16'd0;

  always @(negedge clk) begin
    if (rst) begin
      prev_ack  = 1'b0;
      prev_ce_n = 1'b1;
      m_halves  = 0;
      m_order   = 4'b0000;
      m_overlap = 0;
      m_oe_cnt  = 0;
      m_we_cnt  = 0;
      m_gap     = 0;
      m_adr_err = 0;
    end else begin
      if (prev_ack) chk("ack_single_cycle", 32'(bus.wb_ack_o), 32'd0);
      if (!bus.fsmc_ce_n && prev_ce_n) begin
        m_halves++;
        m_adr = bus.fsmc_adr;
        if (!bus.fsmc_lb_n && bus.fsmc_ub_n)      m_order = {m_order[1:0], 2'b01};
        else if (!bus.fsmc_ub_n && bus.fsmc_lb_n) m_order = {m_order[1:0], 2'b10};
        else                                      m_order = {m_order[1:0], 2'b11};
      end
      if (!bus.fsmc_ce_n && bus.fsmc_adr != m_adr) m_adr_err++;
      if (!bus.fsmc_we_n && !bus.fsmc_oe_n) m_overlap++;
      if (!bus.fsmc_oe_n) m_oe_cnt++;
      if (!bus.fsmc_we_n) m_we_cnt++;
      if (bus.fsmc_ce_n && m_halves == 1) m_gap++;
      prev_ce_n = bus.fsmc_ce_n;

      if (bus.wb_ack_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          exp_t e;
          int   n;
          e = exp_q.pop_front();
          n = int'(e.halves);
          chk("rdata", bus.wb_dat_o, e.rdat);
          chk("ack_latency", 32'(cyc_cnt) - e.start, 32'(1 + n * HALF_CYC));
          chk("fsmc_halves", 32'(m_halves), 32'(n));
          chk("half_order", 32'(m_order), 32'(e.order));
          chk("we_oe_overlap", 32'(m_overlap), 32'd0);
          chk("oe_low_cycles", 32'(m_oe_cnt), e.we ? 32'd0 : 32'(n * DATAST));
          chk("we_low_cycles", 32'(m_we_cnt), e.we ? 32'(n * (ADDSET + DATAST)) : 32'd0);
          if (n > 0) begin
            chk("fsmc_adr", 32'(m_adr), 32'(e.adr));
            chk("fsmc_adr_stable", 32'(m_adr_err), 32'd0);
          end
          if (n == 2) chk("ce_gap", 32'(m_gap), 32'(TURN));
        end
        m_halves  = 0;
        m_order   = 4'b0000;
        m_overlap = 0;
        m_oe_cnt  = 0;
        m_we_cnt  = 0;
        m_gap     = 0;
        m_adr_err = 0;
      end
      prev_ack = bus.wb_ack_o;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.wb_adr_i = 32'd0;
    bus.wb_dat_i = 32'd0;
    bus.wb_sel_i = 4'd0;
    bus.wb_we_i  = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      init_lo[i] = 16'($urandom_range(0, 16'hffff));
      init_hi[i] = 16'($urandom_range(0, 16'hffff));
    end
    init_lo[1] = 16'h1234;
    init_hi[2] = 16'habcd;
    ref_reload();

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_strobes", {27'd0, bus.fsmc_ce_n, bus.fsmc_we_n, bus.fsmc_oe_n,
                          bus.fsmc_ub_n, bus.fsmc_lb_n}, 32'h1f);
    chk("reset_ack", 32'(bus.wb_ack_o), 32'd0);
    chk("reset_dat_o", bus.wb_dat_o, 32'd0);
    chk("reset_adr", 32'(bus.fsmc_adr), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed accesses.
    do_access(32'h0000_0040, 32'hDEAD_BEEF, 4'b1111, 1'b1, 1'b0);
    do_access(32'h0000_0044, 32'h0,         4'b0011, 1'b0, 1'b0);
    do_access(32'h0000_0048, 32'h0,         4'b1100, 1'b0, 1'b0);
    do_access(32'h0000_004C, 32'h5555_AAAA, 4'b0000, 1'b1, 1'b0);
    do_access(32'h0000_004C, 32'h0,         4'b0000, 1'b0, 1'b0);
    do_access(32'hFFFF_0040, 32'h0,         4'b1111, 1'b0, 1'b0);
    do_access(32'h0000_0050, 32'h1357_2468, 4'b0010, 1'b1, 1'b1);
    do_access(32'h0000_0050, 32'h0,         4'b1111, 1'b0, 1'b0);

    // Reset in the middle of a write strobe.
    bus.wb_adr_i = 32'h0000_0100;
    bus.wb_dat_i = $urandom;
    bus.wb_sel_i = 4'b1111;
    bus.wb_we_i  = 1'b1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_reset_we_low", 32'(bus.fsmc_we_n), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midreset_strobes", {27'd0, bus.fsmc_ce_n, bus.fsmc_we_n, bus.fsmc_oe_n,
                             bus.fsmc_ub_n, bus.fsmc_lb_n}, 32'h1f);
    chk("midreset_ack", 32'(bus.wb_ack_o), 32'd0);
    chk("midreset_dat_o", bus.wb_dat_o, 32'd0);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    repeat (2) @(negedge clk);
    ref_reload();
    rst = 1'b0;
    @(negedge clk);

    // Randomised accesses after reset.
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      a = {16'($urandom_range(0, 16'hffff)), 11'h002, 3'($urandom_range(0, 7)), 2'b00};
      do_access(a, $urandom, 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
